// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit.
package rv_ctrl_pkg;

  localparam int unsigned OP_W = 7;

  // Major opcodes
  localparam logic [OP_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OP_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OP_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OPC_SYSTEM = 7'b1110011;

  // funct7 values recognised on OP
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // SYSTEM immediates that halt the core
  localparam logic [11:0] IMM_ECALL  = 12'h000;
  localparam logic [11:0] IMM_EBREAK = 12'h001;

  // imm_sel encoding
  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_I    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;

  // alu_op encoding
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_MUL   = 2'b11;

  // result_src encoding
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_MUL = 2'b11;

  // ALU operand selects
  localparam logic [1:0] SRCA_RS1   = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_ZERO  = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EXEC    = 4'd2,
    ST_ALUWB   = 4'd3,
    ST_MEMADR  = 4'd4,
    ST_MEMRD   = 4'd5,
    ST_MEMWB   = 4'd6,
    ST_MEMWR   = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_JUMP    = 4'd9,
    ST_MULWAIT = 4'd10,
    ST_HALTED  = 4'd11,
    ST_FAULT   = 4'd12
  } state_e;

  typedef enum logic [3:0] {
    CL_ALU_R   = 4'd0,
    CL_ALU_I   = 4'd1,
    CL_LUI     = 4'd2,
    CL_AUIPC   = 4'd3,
    CL_LOAD    = 4'd4,
    CL_STORE   = 4'd5,
    CL_BRANCH  = 4'd6,
    CL_JAL     = 4'd7,
    CL_JALR    = 4'd8,
    CL_MUL     = 4'd9,
    CL_HALT    = 4'd10,
    CL_ILLEGAL = 4'd11
  } iclass_e;

  // Datapath control bundle driven every cycle
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [2:0] imm_sel;
    logic       branch;
    logic       mul_start;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/rv_main_decoder.sv
// Classifies the latched instruction and picks its immediate format.
module rv_main_decoder
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned SUPPORT_M = 0
) (
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] imm,
  output iclass_e     iclass_o,
  output logic [2:0]  imm_sel_o,
  output logic        legal_o
);

  // Opcode/funct decode to instruction class
  always_comb begin
    iclass_o  = CL_ILLEGAL;
    imm_sel_o = IMM_NONE;
    case (op)
      OPC_LOAD: begin
        iclass_o  = CL_LOAD;
        imm_sel_o = IMM_I;
      end
      OPC_STORE: begin
        iclass_o  = CL_STORE;
        imm_sel_o = IMM_S;
      end
      OPC_OP_IMM: begin
        iclass_o  = CL_ALU_I;
        imm_sel_o = IMM_I;
      end
      OPC_OP: begin
        if (funct7 == F7_BASE || funct7 == F7_ALT) begin
          iclass_o = CL_ALU_R;
        end else if (funct7 == F7_MULDIV && SUPPORT_M != 0) begin
          iclass_o = CL_MUL;
        end
      end
      OPC_LUI: begin
        iclass_o  = CL_LUI;
        imm_sel_o = IMM_U;
      end
      OPC_AUIPC: begin
        iclass_o  = CL_AUIPC;
        imm_sel_o = IMM_U;
      end
      OPC_JAL: begin
        iclass_o  = CL_JAL;
        imm_sel_o = IMM_J;
      end
      OPC_JALR: begin
        iclass_o  = CL_JALR;
        imm_sel_o = IMM_I;
      end
      OPC_BRANCH: begin
        iclass_o  = CL_BRANCH;
        imm_sel_o = IMM_B;
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'b000 && (imm == IMM_ECALL || imm == IMM_EBREAK)) begin
          iclass_o = CL_HALT;
        end
      end
      default: ;
    endcase
  end

  assign legal_o = (iclass_o != CL_ILLEGAL);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with memory handshake timeout and optional MUL sequencing.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned SUPPORT_M   = 0,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] imm,
  input  logic        mem_ready,
  input  logic        mul_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  result_src,
  output logic [2:0]  imm_sel,
  output logic        branch,
  output logic        mul_start,
  output logic        retire,
  output logic        halted,
  output logic        fault,
  output logic [3:0]  state_o
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;

  iclass_e    iclass;
  logic [2:0] dec_imm_sel;
  logic       dec_legal;
  ctrl_t      ctrl, ctrl_out;

  rv_main_decoder #(
    .SUPPORT_M (SUPPORT_M)
  ) u_dec (
    .op        (op),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .iclass_o  (iclass),
    .imm_sel_o (dec_imm_sel),
    .legal_o   (dec_legal)
  );

  // State, wait counter and sticky status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = '0;

    case (state_q)
      ST_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ctrl.imm_sel = dec_imm_sel;
        if (!dec_legal) begin
          state_d = ST_FAULT;
        end else begin
          case (iclass)
            CL_LOAD, CL_STORE:                   state_d = ST_MEMADR;
            CL_ALU_R, CL_ALU_I, CL_LUI, CL_AUIPC: state_d = ST_EXEC;
            CL_BRANCH:                           state_d = ST_BRANCH;
            CL_JAL, CL_JALR:                     state_d = ST_JUMP;
            CL_HALT:                             state_d = ST_HALTED;
            CL_MUL: begin
              ctrl.mul_start = 1'b1;
              state_d        = ST_MULWAIT;
            end
            default:                             state_d = ST_FAULT;
          endcase
        end
      end
      ST_EXEC: begin
        ctrl.imm_sel = dec_imm_sel;
        case (iclass)
          CL_ALU_R: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_RS2;
            ctrl.alu_op    = ALU_FUNCT;
          end
          CL_ALU_I: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_FUNCT;
          end
          CL_LUI: begin
            ctrl.alu_src_a = SRCA_ZERO;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
          end
          CL_AUIPC: begin
            ctrl.alu_src_a = SRCA_OLDPC;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
          end
          default: ;
        endcase
        state_d = ST_ALUWB;
      end
      ST_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_ALU;
        ctrl.retire     = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_MEMADR: begin
        ctrl.imm_sel   = dec_imm_sel;
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_d        = (iclass == CL_STORE) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_src = 1'b1;
        if (mem_ready) begin
          state_d = ST_MEMWB;
        end
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.retire     = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_we   = 1'b1;
        ctrl.addr_src = 1'b1;
        if (mem_ready) begin
          ctrl.retire = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        ctrl.imm_sel = dec_imm_sel;
        ctrl.alu_op  = ALU_BR;
        ctrl.branch  = 1'b1;
        ctrl.retire  = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_JUMP: begin
        ctrl.imm_sel    = dec_imm_sel;
        ctrl.alu_src_a  = (iclass == CL_JAL) ? SRCA_OLDPC : SRCA_RS1;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALU_ADD;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.pc_write   = 1'b1;
        ctrl.retire     = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_MULWAIT: begin
        ctrl.alu_op     = ALU_MUL;
        ctrl.result_src = RES_MUL;
        if (mul_done) begin
          ctrl.reg_write = 1'b1;
          ctrl.retire    = 1'b1;
          state_d        = ST_FETCH;
        end
      end
      ST_HALTED: ;
      ST_FAULT:  ;
      default:   state_d = ST_FAULT;
    endcase

    // Memory wait accounting: count unanswered request cycles, fault once the budget is spent
    if (ctrl.mem_req && !mem_ready) begin
      if (cnt_q == CNT_MAX) begin
        state_d = ST_FAULT;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (state_d != state_q) begin
      cnt_d = '0;
    end

    halted_d = halted_q | (state_d == ST_HALTED);
    fault_d  = fault_q  | (state_d == ST_FAULT);
  end

  // Nothing commits while reset is asserted, even mid-handshake
  assign ctrl_out = rst_n ? ctrl : '0;

  assign mem_req    = ctrl_out.mem_req;
  assign mem_we     = ctrl_out.mem_we;
  assign addr_src   = ctrl_out.addr_src;
  assign ir_write   = ctrl_out.ir_write;
  assign pc_write   = ctrl_out.pc_write;
  assign reg_write  = ctrl_out.reg_write;
  assign alu_src_a  = ctrl_out.alu_src_a;
  assign alu_src_b  = ctrl_out.alu_src_b;
  assign alu_op     = ctrl_out.alu_op;
  assign result_src = ctrl_out.result_src;
  assign imm_sel    = ctrl_out.imm_sel;
  assign branch     = ctrl_out.branch;
  assign mul_start  = ctrl_out.mul_start;
  assign retire     = ctrl_out.retire;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign state_o    = 4'(state_q);

endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Multi-cycle control unit for the RV32I core: a registered FSM that sequences fetch, decode, execute, memory and write-back over several clocks, replacing single-cycle opcode decode. It drives the shared ALU/memory datapath, handles variable-latency memory through a `mem_req`/`mem_ready` handshake with a timeout, and optionally sequences a multi-cycle multiplier (RV32M MUL group). It sits between the instruction register and the datapath muxes, PC and register-file write enables.

## Interface
- `SUPPORT_M`, 0: 1 makes R-type with funct7=0000001 legal and routes it through the MULWAIT state.
- `MEM_TIMEOUT`, 15: maximum wait cycles per memory access before FAULT (≥1); counter width is `$clog2(MEM_TIMEOUT+1)`.

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `op`  in  7  opcode from instruction register
- `funct3`  in  3  funct3 field
- `funct7`  in  7  funct7 field
- `imm`  in  12  instr[31:20], used for ECALL/EBREAK halt detect
- `mem_ready`  in  1  memory completes current access this cycle
- `mul_done`  in  1  multiplier result valid (ignored if SUPPORT_M=0)
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  write access (store)
- `addr_src`  out  1  0: PC drives memory address, 1: ALU result register
- `ir_write`  out  1  latch fetched instruction, PC+4 into old-PC register
- `pc_write`  out  1  load PC from next-PC mux
- `reg_write`  out  1  register-file write enable
- `alu_src_a`  out  2  00 rs1, 01 old PC, 10 zero (LUI)
- `alu_src_b`  out  2  00 rs2, 01 immediate, 10 constant 4
- `alu_op`  out  2  00 add, 01 branch compare, 10 funct-decoded, 11 multiply
- `result_src`  out  2  00 ALU result register, 01 memory data, 10 PC+4, 11 multiplier
- `imm_sel`  out  3  001 I, 010 S, 011 B, 100 U, 101 J, 000 none
- `branch`  out  1  PC loads branch target if comparator true
- `mul_start`  out  1  one-cycle multiplier start pulse
- `retire`  out  1  one-cycle pulse in an instruction's final cycle
- `halted`  out  1  sticky, ECALL/EBREAK executed
- `fault`  out  1  sticky, illegal opcode or memory timeout
- `state_o`  out  4  current state encoding, debug

## Operation
- States: FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP, MULWAIT, HALTED, FAULT.
- FETCH: mem_req=1, addr_src=0. On mem_ready: ir_write=1, pc_write=1 (PC+4), go to DECODE. Otherwise stay and increment wait counter.
- DECODE: imm_sel from the latched op. Transitions:
  - LOAD/STORE → MEMADR
  - R-type, I-type ALU, LUI, AUIPC → EXEC
  - MUL-group (SUPPORT_M=1) → MULWAIT with mul_start=1
  - BRANCH → BRANCH
  - JAL/JALR → JUMP
  - SYSTEM with funct3=000 and imm∈{000,001} → HALTED
  - anything else → FAULT
- EXEC → ALUWB. ALU operand selection:
  - R-type: rs1/rs2, alu_op=10
  - I-type: rs1/imm, alu_op=10
  - LUI: zero/imm
  - AUIPC: oldPC/imm
- ALUWB: reg_write=1, result_src=00, retire=1, → FETCH.
- MEMADR: rs1+imm, alu_op=00. Load → MEMRD, store → MEMWR.
- MEMRD: mem_req=1, addr_src=1. On mem_ready → MEMWB.
- MEMWB: reg_write=1, result_src=01, retire=1.
- MEMWR: mem_req=1, mem_we=1, addr_src=1. On mem_ready: retire=1, → FETCH.
- BRANCH: alu_op=01, branch=1, retire=1, → FETCH.
- JUMP: reg_write=1, result_src=10, pc_write=1, retire=1, → FETCH. Target is oldPC+imm(J) for JAL, rs1+imm(I) for JALR.
- MULWAIT: hold until mul_done, then reg_write=1, result_src=11, retire=1, → FETCH.
- Wait counter: cleared on entry to any memory state and on mem_ready. If it reaches MEM_TIMEOUT without mem_ready, → FAULT.
- HALTED and FAULT are absorbing: all enables 0. Only reset leaves them.
- Outputs are Moore outputs decoded from the state register and latched op/funct fields, except ir_write/pc_write/retire in handshake states, which also AND in mem_ready or mul_done.

## Timing
- Reset: state=FETCH, counter=0, halted=0, fault=0. The first cycle after reset has mem_req=1, addr_src=0, and every other output 0.
- Cycles per instruction with zero wait states:
  - branch, JAL, JALR: 3
  - ALU, LUI, AUIPC, store: 4
  - load: 5
  - MUL: 3 + mul latency
- Each memory wait state adds 1 cycle.
- mem_ready asserted in the same cycle as mem_req completes the access in that cycle.
- mem_ready outside a request state is ignored.
- Reset mid-instruction returns to FETCH on the next edge. Partial writes are not committed.
- mul_done and a timeout cannot coincide; MULWAIT has no timeout.

## Structure
- Package `rv_ctrl_pkg` holds:
  - opcode localparams (LOAD, STORE, OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, SYSTEM)
  - state enum
  - imm_sel, alu_op and result_src encodings
- Sub-module `rv_main_decoder` is combinational: op/funct fields → instruction class, imm_sel, legality.
- The FSM and wait counter live in the top module.

## Test plan
- `add` (op=0110011), mem_ready held high → FETCH, DECODE, EXEC, ALUWB. reg_write=1 in cycle 4 only; retire pulses once.
- Load with mem_ready delayed 3 cycles in MEMRD → 8 total cycles; mem_req stays high through the waits; reg_write with result_src=01 in the final cycle.
- Fetch with mem_ready never asserted and MEM_TIMEOUT=15 → fault=1 on cycle 17 after reset, then stays 1 with all enables 0.
- op=1110011, funct3=000, imm=001 → halted=1 after DECODE. A later valid instruction is ignored until rst_n=0.
- Illegal op=1111111 → FAULT. With SUPPORT_M=0, funct7=0000001 also → FAULT. With SUPPORT_M=1, the same instruction pulses mul_start, waits for mul_done at cycle 7, and writes with result_src=11.
- rst_n=0 during MEMWR → no retire; FETCH outputs appear on the next cycle.
